press_classifier: RTL

- Sits directly downstream of the debouncer and consumes its clean level output `d`.
- Classifies each button gesture into exactly one of short press, double press or long press, and reports it as a single-cycle event pulse.
- Feeds the top-level control logic (LED/mode control), so that logic never sees raw levels.

---
 rtl/press_classifier_pkg.sv | 25 ++
 rtl/press_timer.sv | 38 +++
 rtl/press_classifier.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/press_classifier_pkg.sv
// press_classifier_pkg: shared types and defaults for the press classifier.
//   state_t : classifier FSM states (IDLE, PRESS1, WAIT2, PRESS2, LONG)
//   event_t : gesture event codes, also usable by benches
//   CNT_W_DEF : default width of the interval counter
package press_classifier_pkg;

  localparam int unsigned CNT_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG
  } state_t;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_SHORT,
    EV_DOUBLE,
    EV_LONG,
    EV_REPEAT
  } event_t;

endpackage

// File: rtl/press_timer.sv
// press_timer: up-counter with synchronous clear and terminal-count flag.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset (counter to 0)
//   i_clr   : synchronous clear (loads 0), has priority over i_en
//   i_en    : count enable; on terminal count the counter restarts at 0
//   i_limit : period in cycles (2 .. 2^CNT_W)
//   o_tc    : high while count == i_limit - 1
module press_timer
  import press_classifier_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_clr,
  input  logic           i_en,
  input  logic [CNT_W:0] i_limit,
  output logic           o_tc
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_last;

  // Limit carries one extra bit so a full 2^CNT_W period is expressible.
  assign w_last = i_limit - {{CNT_W{1'b0}}, 1'b1};
  assign o_tc   = ({1'b0, r_cnt} == w_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/press_classifier.sv
// press_classifier: classifies debounced button gestures into short, double
// or long presses and reports each as a single-cycle registered pulse.
//   clk          : system clock
//   rst          : asynchronous active-low reset
//   d            : debounced button level
//   short_press  : pulse, single short press
//   double_press : pulse, second press started within DBL_WINDOW of release
//   long_press   : pulse, press held LONG_CYCLES
//   repeat_press : pulse every REPEAT_CYCLES while long-held
//   busy         : high while a gesture is in progress
// Optional feature: define PRESS_CLASSIFIER_REPEAT_EN to enable auto-repeat;
// otherwise repeat_press is tied to 0 and no repeat counter is built.
module press_classifier
  import press_classifier_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = 20000000,
  parameter int unsigned DBL_WINDOW    = 10000000,
  parameter int unsigned REPEAT_CYCLES = 5000000,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_press,
  output logic busy
);

  if (LONG_CYCLES < 2 || DBL_WINDOW < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("press_classifier: interval parameters must be at least 2");
  end

  state_t         r_state, w_state_nxt;
  event_t         r_evt, w_evt;
  logic           r_d_q;
  logic           r_short, r_double, r_long, r_busy;
  logic           w_rise, w_fall;
  logic           w_cnt_clr, w_cnt_en, w_cnt_tc;
  logic [CNT_W:0] w_limit;

  assign w_rise = d & ~r_d_q;
  assign w_fall = ~d & r_d_q;

  // One counter serves both timed states; the limit follows the state.
  assign w_limit = (r_state == PRESS1) ? (CNT_W + 1)'(LONG_CYCLES)
                                       : (CNT_W + 1)'(DBL_WINDOW);

  press_timer #(.CNT_W(CNT_W)) u_interval (
    .clk    (clk),
    .rst_n  (rst),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .i_limit(w_limit),
    .o_tc   (w_cnt_tc)
  );

`ifdef PRESS_CLASSIFIER_REPEAT_EN
  logic w_rep_clr, w_rep_en, w_rep_tc, r_repeat;

  press_timer #(.CNT_W(CNT_W)) u_repeat (
    .clk    (clk),
    .rst_n  (rst),
    .i_clr  (w_rep_clr),
    .i_en   (w_rep_en),
    .i_limit((CNT_W + 1)'(REPEAT_CYCLES)),
    .o_tc   (w_rep_tc)
  );
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_evt       = EV_NONE;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
`ifdef PRESS_CLASSIFIER_REPEAT_EN
    w_rep_clr   = 1'b0;
    w_rep_en    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = PRESS1;
          w_cnt_clr   = 1'b1;
        end
      end
      PRESS1: begin
        // A release on the terminal edge is still a short/double candidate.
        if (w_fall) begin
          w_state_nxt = WAIT2;
          w_cnt_clr   = 1'b1;
        end else if (w_cnt_tc) begin
          w_state_nxt = LONG;
          w_evt       = EV_LONG;
`ifdef PRESS_CLASSIFIER_REPEAT_EN
          w_rep_clr   = 1'b1;
`endif
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      WAIT2: begin
        // A second press on the timeout edge still makes a double press.
        if (w_rise) begin
          w_state_nxt = PRESS2;
        end else if (w_cnt_tc) begin
          w_state_nxt = IDLE;
          w_evt       = EV_SHORT;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      PRESS2: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
          w_evt       = EV_DOUBLE;
        end
      end
      LONG: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
        end
`ifdef PRESS_CLASSIFIER_REPEAT_EN
        else begin
          w_rep_en = 1'b1;
          if (w_rep_tc) begin
            w_evt = EV_REPEAT;
          end
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Events are latched at the decision edge and turned into output pulses
  // on the following edge; busy is delayed by the same stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d_q    <= 1'b0;
      r_state  <= IDLE;
      r_evt    <= EV_NONE;
      r_short  <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_d_q    <= d;
      r_state  <= w_state_nxt;
      r_evt    <= w_evt;
      r_short  <= (r_evt == EV_SHORT);
      r_double <= (r_evt == EV_DOUBLE);
      r_long   <= (r_evt == EV_LONG);
      r_busy   <= (r_state != IDLE);
    end
  end

`ifdef PRESS_CLASSIFIER_REPEAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_repeat <= 1'b0;
    end else begin
      r_repeat <= (r_evt == EV_REPEAT);
    end
  end
  assign repeat_press = r_repeat;
`else
  assign repeat_press = 1'b0;
`endif

  assign short_press  = r_short;
  assign double_press = r_double;
  assign long_press   = r_long;
  assign busy         = r_busy;

endmodule
